// File: rtl/data_memory_bytelane.sv
// Byte-addressable data memory with a valid/ready request channel and a one-deep registered response.
// Define DMEM_IOPORT_EN to add the io_out/io_in port mapped at req_addr[15]=1.
module data_memory_bytelane #(
  parameter int    ADDR_BITS = 5,
  parameter int    DATA_W    = 32,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_IOPORT_EN
  ,
  output logic [31:0] io_out,
  input  logic [31:0] io_in
`endif
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic {EMPTY, FULL} rsp_state_t;

  if (DATA_W != 32) begin : g_bad_width
    $error("data_memory_bytelane: DATA_W must be 32");
  end

  logic [31:0] mem [DEPTH];

  rsp_state_t          state_q;
  rsp_state_t          state_d;
  logic                accept;
  logic                misaligned;
  logic                is_io;
  logic                mem_we;
  logic                io_we;
  logic [ADDR_BITS-1:0] word_idx;
  logic [3:0]          byte_en;
  logic [31:0]         wdata_lanes;
  logic [31:0]         rd_word;
  logic [31:0]         rd_lane;
  logic [31:0]         load_ext;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:ADDR_BITS+2];

  assign accept   = req_valid & req_ready;
  assign word_idx = req_addr[ADDR_BITS+1:2];

`ifdef DMEM_IOPORT_EN
  assign is_io = req_addr[15];
`else
  assign is_io = 1'b0;
`endif

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Store data is replicated across lanes so each enabled byte lane simply picks its own slice.
  always_comb begin
    byte_en     = 4'b0000;
    wdata_lanes = req_wdata;
    case (req_size)
      2'b00: begin
        byte_en     = 4'b0001 << req_addr[1:0];
        wdata_lanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        byte_en     = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        byte_en     = 4'b1111;
        wdata_lanes = req_wdata;
      end
      default: begin
        byte_en     = 4'b0000;
        wdata_lanes = req_wdata;
      end
    endcase
  end

  assign mem_we = accept & req_write & ~misaligned & ~is_io & ~rst;
  assign io_we  = accept & req_write & ~misaligned & is_io;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
      end
    end
  end

`ifdef DMEM_IOPORT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_out <= 32'h0;
    end else if (io_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) io_out[8*b +: 8] <= wdata_lanes[8*b +: 8];
      end
    end
  end

  assign rd_word = is_io ? io_in : mem[word_idx];
`else
  assign rd_word = mem[word_idx];
`endif

  assign rd_lane = rd_word >> {req_addr[1:0], 3'b000};

  always_comb begin
    load_ext = 32'h0;
    case (req_size)
      2'b00:   load_ext = {{24{rd_lane[7] & ~req_unsigned}}, rd_lane[7:0]};
      2'b01:   load_ext = {{16{rd_lane[15] & ~req_unsigned}}, rd_lane[15:0]};
      2'b10:   load_ext = rd_word;
      default: load_ext = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept)                            state_d = FULL;
    else if (state_q == FULL && rsp_ready) state_d = EMPTY;
  end

  always_comb begin
    rsp_valid = (state_q == FULL);
    req_ready = (state_q == EMPTY) | rsp_ready;
  end

  // Response payload only changes on accept, so it stays stable while back-pressured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_err   <= misaligned;
      rsp_rdata <= (req_write | misaligned) ? 32'h0 : load_ext;
    end
  end

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Directed self-checking bench for data_memory_bytelane; IO-port steps run when DMEM_IOPORT_EN is defined.
module tb_data_memory_bytelane;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
`ifdef DMEM_IOPORT_EN
  logic [31:0] io_out;
  logic [31:0] io_in;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  data_memory_bytelane #(.ADDR_BITS(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
`ifdef DMEM_IOPORT_EN
    ,
    .io_out       (io_out),
    .io_in        (io_in)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Presents one request, waits (bounded) for acceptance, and returns 1ns after the accepting edge.
  task automatic applyStimulus(input string tag, input logic wr, input logic [31:0] addr,
                               input logic [1:0] size, input logic uns, input logic [31:0] wd);
    int waited;
    waited = 0;
    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = wr;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wd;
    while (!req_ready && waited < 16) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
  endtask

  task automatic checkRsp(input string tag, input logic [31:0] rdata, input logic err);
    checkOutput({tag, "_rdata"}, rsp_rdata, rdata);
    checkOutput({tag, "_err"}, {31'b0, rsp_err}, {31'b0, err});
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_addr     = 32'h0;
    req_size     = SZ_W;
    req_unsigned = 1'b0;
    req_wdata    = 32'h0;
    rsp_ready    = 1'b1;
`ifdef DMEM_IOPORT_EN
    io_in        = 32'h0000_1234;
`endif
    $display("[TB] starting data_memory_bytelane directed test");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("reset_req_ready", {31'b0, req_ready}, 32'd1);
    checkRsp("reset", 32'h0, 1'b0);
`ifdef DMEM_IOPORT_EN
    checkOutput("reset_io_out", io_out, 32'h0);
`endif

    applyStimulus("sw8", 1'b1, 32'h8, SZ_W, 1'b0, 32'hDEAD_BEEF);
    checkRsp("sw8", 32'h0, 1'b0);
    applyStimulus("lw8", 1'b0, 32'h8, SZ_W, 1'b0, 32'h0);
    checkRsp("lw8", 32'hDEAD_BEEF, 1'b0);

    applyStimulus("sb9", 1'b1, 32'h9, SZ_B, 1'b0, 32'hFFFF_FF7F);
    applyStimulus("sba", 1'b1, 32'hA, SZ_B, 1'b0, 32'h0000_0080);
    applyStimulus("lw8_merged", 1'b0, 32'h8, SZ_W, 1'b0, 32'h0);
    checkRsp("lw8_merged", 32'hDE80_7FEF, 1'b0);
    applyStimulus("lb_a", 1'b0, 32'hA, SZ_B, 1'b0, 32'h0);
    checkRsp("lb_a", 32'hFFFF_FF80, 1'b0);
    applyStimulus("lbu_a", 1'b0, 32'hA, SZ_B, 1'b1, 32'h0);
    checkRsp("lbu_a", 32'h0000_0080, 1'b0);
    applyStimulus("lh_8", 1'b0, 32'h8, SZ_H, 1'b0, 32'h0);
    checkRsp("lh_8", 32'h0000_7FEF, 1'b0);
    applyStimulus("lh_a", 1'b0, 32'hA, SZ_H, 1'b0, 32'h0);
    checkRsp("lh_a", 32'hFFFF_DE80, 1'b0);
    applyStimulus("lhu_a", 1'b0, 32'hA, SZ_H, 1'b1, 32'h0);
    checkRsp("lhu_a", 32'h0000_DE80, 1'b0);

    applyStimulus("sw_c", 1'b1, 32'hC, SZ_W, 1'b0, 32'h0);
    applyStimulus("sh_e", 1'b1, 32'hE, SZ_H, 1'b0, 32'h1234_ABCD);
    checkRsp("sh_e", 32'h0, 1'b0);
    applyStimulus("lw_c", 1'b0, 32'hC, SZ_W, 1'b0, 32'h0);
    checkRsp("lw_c", 32'hABCD_0000, 1'b0);

    applyStimulus("sw4", 1'b1, 32'h4, SZ_W, 1'b0, 32'hCAFE_F00D);
    applyStimulus("lh_3", 1'b0, 32'h3, SZ_H, 1'b0, 32'h0);
    checkRsp("lh_3", 32'h0, 1'b1);
    applyStimulus("sw_6", 1'b1, 32'h6, SZ_W, 1'b0, 32'h1234_5678);
    checkRsp("sw_6", 32'h0, 1'b1);
    applyStimulus("lw4_after_err", 1'b0, 32'h4, SZ_W, 1'b0, 32'h0);
    checkRsp("lw4_after_err", 32'hCAFE_F00D, 1'b0);
    applyStimulus("size11_load", 1'b0, 32'h4, SZ_X, 1'b0, 32'h0);
    checkRsp("size11_load", 32'h0, 1'b1);
    applyStimulus("size11_store", 1'b1, 32'h4, SZ_X, 1'b0, 32'h0);
    checkRsp("size11_store", 32'h0, 1'b1);
    applyStimulus("lw4_after_size11", 1'b0, 32'h4, SZ_W, 1'b0, 32'h0);
    checkRsp("lw4_after_size11", 32'hCAFE_F00D, 1'b0);

    applyStimulus("sw_80", 1'b1, 32'h80, SZ_W, 1'b0, 32'h1111_1111);
    applyStimulus("lw_0_wrap", 1'b0, 32'h0, SZ_W, 1'b0, 32'h0);
    checkRsp("lw_0_wrap", 32'h1111_1111, 1'b0);
`ifndef DMEM_IOPORT_EN
    applyStimulus("lw_8008_alias", 1'b0, 32'h8008, SZ_W, 1'b0, 32'h0);
    checkRsp("lw_8008_alias", 32'hDE80_7FEF, 1'b0);
`endif

    // Back-pressure: hold the load response for three cycles with a new request waiting.
    applyStimulus("bp_lw8", 1'b0, 32'h8, SZ_W, 1'b0, 32'h0);
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h4;
    req_size  = SZ_W;
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_req_ready", {31'b0, req_ready}, 32'd0);
      checkOutput("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      checkRsp("bp_hold", 32'hDE80_7FEF, 1'b0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("bp_next_valid", {31'b0, rsp_valid}, 32'd1);
    checkRsp("bp_next", 32'hCAFE_F00D, 1'b0);

`ifdef DMEM_IOPORT_EN
    applyStimulus("io_sw", 1'b1, 32'h8000, SZ_W, 1'b0, 32'hA5A5_A5A5);
    checkRsp("io_sw", 32'h0, 1'b0);
    checkOutput("io_out_word", io_out, 32'hA5A5_A5A5);
    applyStimulus("io_lw0", 1'b0, 32'h0, SZ_W, 1'b0, 32'h0);
    checkRsp("io_lw0", 32'h1111_1111, 1'b0);
    applyStimulus("io_lh", 1'b0, 32'h8000, SZ_H, 1'b0, 32'h0);
    checkRsp("io_lh", 32'h0000_1234, 1'b0);
    applyStimulus("io_sb", 1'b1, 32'h8001, SZ_B, 1'b0, 32'h0000_0000);
    checkOutput("io_out_byte", io_out, 32'hA5A5_00A5);
`endif

    // Reset with a pending response, and a store presented across the reset edge.
    applyStimulus("rst_lw8", 1'b0, 32'h8, SZ_W, 1'b0, 32'h0);
    rsp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkRsp("midrst", 32'h0, 1'b0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h4;
    req_size  = SZ_W;
    req_wdata = 32'h0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst       = 1'b0;
    rsp_ready = 1'b1;
    #1;
    checkOutput("postrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
`ifdef DMEM_IOPORT_EN
    checkOutput("postrst_io_out", io_out, 32'h0);
`endif
    applyStimulus("lw4_after_rst", 1'b0, 32'h4, SZ_W, 1'b0, 32'h0);
    checkRsp("lw4_after_rst", 32'hCAFE_F00D, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
